dds_multi_ch: RTL and testbench
===============================

DDS_MULTI_CH -- requirements
Module: dds_multi_ch

Interface
REQ-001 SHALL have parameter CH_NUM, default 3: number of independent DDS channels (1..8).
REQ-002 SHALL have parameter PHASE_W, default 32: phase-accumulator and frequency-word width.
REQ-003 SHALL have parameter ADDR_W, default 8: waveform address width; ADDR_W <= PHASE_W.
REQ-004 SHALL have parameter DATA_W, default 8: sample width; DATA_W <= ADDR_W.
REQ-005 SHALL have port clk, input, 1: the single clock, rising edge.
REQ-006 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-007 SHALL have port en, input, 1: global run enable.
REQ-008 SHALL have port wr_en, input, 1: shadow-register write strobe.
REQ-009 SHALL have port wr_ch, input, 3: target channel of the write.
REQ-010 SHALL have port wr_sel, input, 2: target field (0 f_word, 1 p_word, 2 mode).
REQ-011 SHALL have port wr_data, input, PHASE_W: write data; p_word uses [ADDR_W-1:0] and mode uses [1:0].
REQ-012 SHALL have port apply, input, 1: copy all shadow registers to active registers.
REQ-013 SHALL have port phase_sync, input, 1: clear all phase accumulators.
REQ-014 SHALL have port dout, output, CH_NUM*DATA_W: packed samples, channel 0 in the LSBs.
REQ-015 SHALL have port dout_vld, output, 1: dout valid.

Function
REQ-016 Each wr_en cycle SHALL write wr_data to the shadow field selected by wr_ch/wr_sel; wr_ch >= CH_NUM or wr_sel == 3 SHALL be ignored.
REQ-017 On apply, the active f_word, p_word and mode SHALL take the shadow values at the next edge, for all channels simultaneously.
REQ-018 A write and an apply in the same cycle SHALL apply the pre-write shadow value; the written value SHALL be applied by the next apply.
REQ-019 When en=1, each accumulator SHALL update as acc <= acc + active f_word, modulo 2^PHASE_W, wrapping silently.
REQ-020 When en=0, accumulators SHALL hold.
REQ-021 phase_sync SHALL clear every accumulator to 0 at the next edge, overriding both en and the increment.
REQ-022 With phase_sync and apply in the same cycle, accumulators SHALL clear and the new f_word SHALL take effect from the following cycle.
REQ-023 Stage 1 SHALL register addr = acc[PHASE_W-1 -: ADDR_W] + p_word, modulo 2^ADDR_W.
REQ-024 Stage 2 SHALL register the sample, so the accumulator value in cycle t appears on dout in cycle t+2.
REQ-025 Mode 0 (saw) SHALL output addr[ADDR_W-1 -: DATA_W].
REQ-026 Mode 1 (triangle) SHALL output t = {addr[ADDR_W-2:0],0} when the addr MSB is 0 and ~t when it is 1, truncated to the top DATA_W bits.
REQ-027 Mode 2 (square) SHALL output all-ones when the addr MSB is 1 and 0 otherwise.
REQ-028 Mode 3 SHALL be as defined in Configuration.
REQ-029 dout_vld SHALL equal en delayed by 2 cycles.
REQ-030 dout SHALL hold its last value while dout_vld=0.

Reset
REQ-031 rst SHALL clear immediately, independent of clk, all accumulators, the shadow and active registers, both pipeline stages, dout and dout_vld to 0.
REQ-032 A rst asserted mid-run SHALL discard in-flight samples.
REQ-033 After rst deasserts, dout_vld SHALL first assert 2 cycles after en is sampled high.

Configuration
REQ-034 With DDS_SINE_EN defined, mode 3 SHALL output a sine derived from a quarter-wave table of 2^(ADDR_W-2) entries with offset-binary mirroring, giving sample(0) = 2^(DATA_W-1) and sample(2^(ADDR_W-2)) = 2^DATA_W - 1.
REQ-035 Without DDS_SINE_EN, no table SHALL be synthesised and mode 3 SHALL behave as mode 2.

Verification
REQ-036 Saw ramp: defaults, ch0 f_word=0x01000000, mode 0, apply, then en=1 -> ch0 dout = 0,1,2,... from 2 cycles after en, wrapping 255 -> 0.
REQ-037 Phase offset: ch1 same as ch0 but p_word=10 -> ch1 dout = ch0 dout + 10 (mod 256) every valid cycle.
REQ-038 Triangle: ch2 mode 1, f_word=0x01000000 -> dout 0,2,...,254 then 255,253,...,1 repeating.
REQ-039 Sync with apply: apply and phase_sync in the same cycle while running -> all channels output addr = p_word two cycles later, then step by the new f_word.
REQ-040 Sine: mode 3, f_word=0x01000000, DDS_SINE_EN defined -> dout 128 at addr 0 and 255 at addr 64; with the macro undefined -> square output, 0 then 255.
REQ-041 Reset mid-run: rst pulsed for 1 cycle -> dout=0 and dout_vld=0 immediately; output resumes from addr 0 only after a new apply.

Source files
------------

// File: rtl/dds_multi_ch.sv
// Multi-channel DDS: per-channel phase accumulator, shadow/active register banks and a two-stage
// waveform pipeline. Define DDS_SINE_EN to build the quarter-wave sine table used by mode 3.
module dds_multi_ch #(
  parameter int CH_NUM  = 3,
  parameter int PHASE_W = 32,
  parameter int ADDR_W  = 8,
  parameter int DATA_W  = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     wr_en,
  input  logic [2:0]               wr_ch,
  input  logic [1:0]               wr_sel,
  input  logic [PHASE_W-1:0]       wr_data,
  input  logic                     apply,
  input  logic                     phase_sync,
  output logic [CH_NUM*DATA_W-1:0] dout,
  output logic                     dout_vld
);

  logic [PHASE_W-1:0]       r_sh_f   [CH_NUM];
  logic [ADDR_W-1:0]        r_sh_p   [CH_NUM];
  logic [1:0]               r_sh_m   [CH_NUM];
  logic [PHASE_W-1:0]       r_act_f  [CH_NUM];
  logic [ADDR_W-1:0]        r_act_p  [CH_NUM];
  logic [1:0]               r_act_m  [CH_NUM];
  logic [PHASE_W-1:0]       r_acc    [CH_NUM];
  logic [ADDR_W-1:0]        r_addr   [CH_NUM];
  logic [1:0]               r_mode1  [CH_NUM];
  logic                     r_vld1;
  logic [CH_NUM*DATA_W-1:0] w_samp_all;

`ifdef DDS_SINE_EN
  localparam int QN = 2 ** (ADDR_W - 2);
  localparam logic [DATA_W-1:0] HALF = DATA_W'(1) << (DATA_W - 1);

  // Bhaskara approximation of sin(pi/2 * i/QN), scaled to the positive half-swing.
  function automatic logic [DATA_W-2:0] f_sine_amp(input longint i);
    longint n, u, a;
    n = longint'(QN);
    u = i * (2 * n - i);
    a = (longint'(1) << (DATA_W - 1)) - 1;
    return (DATA_W-1)'((4 * a * u + (5 * n * n - u) / 2) / (5 * n * n - u));
  endfunction

  logic [DATA_W-2:0] w_qtab [QN];
  for (genvar i = 0; i < QN; i++) begin : g_tab
    assign w_qtab[i] = f_sine_amp(longint'(i));
  end
`endif

  for (genvar c = 0; c < CH_NUM; c++) begin : g_ch
    logic [ADDR_W-1:0] w_tri;
    logic [DATA_W-1:0] w_sq;
    logic [DATA_W-1:0] w_m3;
    logic [DATA_W-1:0] w_samp;

    assign w_tri = r_addr[c][ADDR_W-1] ? ~{r_addr[c][ADDR_W-2:0], 1'b0}
                                       :  {r_addr[c][ADDR_W-2:0], 1'b0};
    assign w_sq  = r_addr[c][ADDR_W-1] ? {DATA_W{1'b1}} : {DATA_W{1'b0}};

`ifdef DDS_SINE_EN
    // Odd quadrants mirror the index; index QN (table end) is the peak, handled explicitly.
    logic [ADDR_W-3:0] w_q;
    logic [DATA_W-2:0] w_amp;
    assign w_q   = r_addr[c][ADDR_W-2] ? (~r_addr[c][ADDR_W-3:0] + (ADDR_W-2)'(1))
                                       : r_addr[c][ADDR_W-3:0];
    assign w_amp = (r_addr[c][ADDR_W-2] && (w_q == '0)) ? {(DATA_W-1){1'b1}} : w_qtab[w_q];
    assign w_m3  = r_addr[c][ADDR_W-1] ? (HALF - {1'b0, w_amp}) : {1'b1, w_amp};
`else
    assign w_m3  = w_sq;
`endif

    always_comb begin
      w_samp = {DATA_W{1'b0}};
      case (r_mode1[c])
        2'd0:    w_samp = r_addr[c][ADDR_W-1 -: DATA_W];
        2'd1:    w_samp = w_tri[ADDR_W-1 -: DATA_W];
        2'd2:    w_samp = w_sq;
        default: w_samp = w_m3;
      endcase
    end

    assign w_samp_all[c*DATA_W +: DATA_W] = w_samp;
  end

  // Register banks, accumulators and both pipeline stages.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int c = 0; c < CH_NUM; c++) begin
        r_sh_f[c]  <= '0;
        r_sh_p[c]  <= '0;
        r_sh_m[c]  <= 2'd0;
        r_act_f[c] <= '0;
        r_act_p[c] <= '0;
        r_act_m[c] <= 2'd0;
        r_acc[c]   <= '0;
        r_addr[c]  <= '0;
        r_mode1[c] <= 2'd0;
      end
      r_vld1   <= 1'b0;
      dout_vld <= 1'b0;
      dout     <= '0;
    end else begin
      for (int c = 0; c < CH_NUM; c++) begin
        if (wr_en && (wr_ch == 3'(c))) begin
          case (wr_sel)
            2'd0:    r_sh_f[c] <= wr_data;
            2'd1:    r_sh_p[c] <= wr_data[ADDR_W-1:0];
            2'd2:    r_sh_m[c] <= wr_data[1:0];
            default: ;
          endcase
        end
        // Apply copies the pre-write shadow; a same-cycle write lands on the next apply.
        if (apply) begin
          r_act_f[c] <= r_sh_f[c];
          r_act_p[c] <= r_sh_p[c];
          r_act_m[c] <= r_sh_m[c];
        end
        if (phase_sync) begin
          r_acc[c] <= '0;
        end else if (en) begin
          r_acc[c] <= r_acc[c] + r_act_f[c];
        end
        r_addr[c]  <= r_acc[c][PHASE_W-1 -: ADDR_W] + r_act_p[c];
        r_mode1[c] <= r_act_m[c];
      end
      r_vld1   <= en;
      dout_vld <= r_vld1;
      if (r_vld1) begin
        dout <= w_samp_all;
      end
    end
  end

endmodule

// File: tb/tb_dds_multi_ch.sv
// Directed self-checking bench for dds_multi_ch (default parameters); sine checks follow DDS_SINE_EN.
module tb_dds_multi_ch;
  logic        clk = 1'b0;
  logic        rst, en, wr_en, apply, phase_sync;
  logic [2:0]  wr_ch;
  logic [1:0]  wr_sel;
  logic [31:0] wr_data;
  logic [23:0] dout;
  logic        dout_vld;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  dds_multi_ch dut (
    .clk(clk), .rst(rst), .en(en), .wr_en(wr_en), .wr_ch(wr_ch), .wr_sel(wr_sel),
    .wr_data(wr_data), .apply(apply), .phase_sync(phase_sync), .dout(dout), .dout_vld(dout_vld)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [2:0] ch, input logic [1:0] sel, input logic [31:0] d);
    wr_en = 1'b1; wr_ch = ch; wr_sel = sel; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  function automatic logic [7:0] chv(input int c);
    return dout[c*8 +: 8];
  endfunction

  function automatic logic [31:0] tri_exp(input int a);
    int m;
    m = a % 256;
    return (m < 128) ? 32'(2 * m) : 32'(255 - 2 * (m - 128));
  endfunction

  initial begin
    int k_last;
    logic [31:0] e2;
    bit do2;
    rst = 1'b1; en = 1'b0; wr_en = 1'b0; apply = 1'b0; phase_sync = 1'b0;
    wr_ch = 3'd0; wr_sel = 2'd0; wr_data = 32'd0;
    #1;
    chk("reset_dout", 32'(dout), 32'd0);
    chk("reset_vld", 32'(dout_vld), 32'd0);
    step(); step();
    rst = 1'b0;

    wr(3'd0, 2'd0, 32'h0100_0000);
    wr(3'd1, 2'd0, 32'h0100_0000);
    wr(3'd1, 2'd1, 32'd10);
    wr(3'd2, 2'd0, 32'h0100_0000);
    wr(3'd2, 2'd2, 32'd1);
    wr(3'd4, 2'd0, 32'h7F00_0000);
    wr(3'd0, 2'd3, 32'd2);
    apply = 1'b1; step(); apply = 1'b0;
    chk("idle_vld", 32'(dout_vld), 32'd0);

    en = 1'b1;
    step();
    chk("latency_vld_low", 32'(dout_vld), 32'd0);
    step();
    chk("first_vld", 32'(dout_vld), 32'd1);
    chk("saw0", 32'(chv(0)), 32'd0);
    chk("offset0", 32'(chv(1)), 32'd10);
    chk("tri0", 32'(chv(2)), 32'd0);
    for (int k = 1; k < 260; k++) begin
      step();
      chk("saw", 32'(chv(0)), 32'(k % 256));
      chk("offset", 32'(chv(1)), 32'((k + 10) % 256));
      chk("tri", 32'(chv(2)), tri_exp(k));
    end
    k_last = 259;

    en = 1'b0;
    step();
    chk("stop_tail_vld", 32'(dout_vld), 32'd1);
    chk("stop_tail_saw", 32'(chv(0)), 32'((k_last + 1) % 256));
    step();
    chk("stop_vld", 32'(dout_vld), 32'd0);
    chk("hold1", 32'(chv(0)), 32'((k_last + 1) % 256));
    step();
    chk("hold2", 32'(chv(0)), 32'((k_last + 1) % 256));
    en = 1'b1;
    step();
    chk("restart_vld_low", 32'(dout_vld), 32'd0);
    chk("restart_hold", 32'(chv(0)), 32'((k_last + 1) % 256));
    step();
    chk("restart_vld", 32'(dout_vld), 32'd1);
    chk("restart_saw", 32'(chv(0)), 32'((k_last + 2) % 256));

    wr(3'd0, 2'd0, 32'h0200_0000);
    wr(3'd0, 2'd1, 32'd5);
    apply = 1'b1; phase_sync = 1'b1;
    wr_en = 1'b1; wr_ch = 3'd1; wr_sel = 2'd1; wr_data = 32'd50;
    step();
    apply = 1'b0; phase_sync = 1'b0; wr_en = 1'b0;
    step(); step();
    chk("sync_ch0", 32'(chv(0)), 32'd5);
    chk("sync_ch1_prewrite", 32'(chv(1)), 32'd10);
    chk("sync_ch2", 32'(chv(2)), 32'd0);
    step();
    chk("sync_step_ch0", 32'(chv(0)), 32'd7);
    chk("sync_step_ch1", 32'(chv(1)), 32'd11);
    chk("sync_step_ch2", 32'(chv(2)), 32'd2);
    step();
    chk("sync_step2_ch0", 32'(chv(0)), 32'd9);

    wr(3'd2, 2'd2, 32'd3);
    apply = 1'b1; phase_sync = 1'b1;
    step();
    apply = 1'b0; phase_sync = 1'b0;
    step(); step();
    chk("reapply_ch1", 32'(chv(1)), 32'd50);
    for (int k = 0; k < 256; k++) begin
      if (k > 0) step();
      chk("f2_ch0", 32'(chv(0)), 32'((5 + 2 * k) % 256));
`ifdef DDS_SINE_EN
      do2 = (k == 0) || (k == 64) || (k == 128) || (k == 192);
      e2 = (k == 64) ? 32'd255 : ((k == 192) ? 32'd1 : 32'd128);
`else
      do2 = (k == 0) || (k == 64) || (k == 127) || (k == 128) || (k == 192) || (k == 255);
      e2 = (k < 128) ? 32'd0 : 32'd255;
`endif
      if (do2) chk("mode3", 32'(chv(2)), e2);
    end

    #2;
    rst = 1'b1;
    #1;
    chk("midrst_dout", 32'(dout), 32'd0);
    chk("midrst_vld", 32'(dout_vld), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    step();
    chk("postrst_vld_low", 32'(dout_vld), 32'd0);
    step();
    chk("postrst_vld", 32'(dout_vld), 32'd1);
    chk("postrst_dout", 32'(dout), 32'd0);
    wr(3'd0, 2'd0, 32'h0100_0000);
    apply = 1'b1; step(); apply = 1'b0;
    step(); step();
    chk("resume0", 32'(chv(0)), 32'd0);
    step();
    chk("resume1", 32'(chv(0)), 32'd1);
    step();
    chk("resume2", 32'(chv(0)), 32'd2);
    chk("resume_ch1_cleared", 32'(chv(1)), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
